pmem_arbiter: RTL and testbench
===============================

# pmem_arbiter

Two-port arbiter placed between the instruction-cache and data-cache controllers and the single physical-memory port. Serializes whole-line (256-bit) transactions from the two caches onto one pmem interface, latches the winning request for its duration, and routes `pmem_resp` back only to the granted cache. Default policy is round-robin between the two caches; a compile-time option forces fixed data-cache priority.

## Interface

**Parameters**
- `LINE_W`, default 256: cache line width in bits.
- `ADDR_W`, default 32: address width; addresses are line-aligned, bits [4:0] = 0.

**Ports**
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `i_pmem_read`  in  1  I-cache line-read request; held until `i_pmem_resp`.
- `i_pmem_address`  in  ADDR_W  I-cache line address.
- `i_pmem_rdata`  out  LINE_W  read line to I-cache.
- `i_pmem_resp`  out  1  I-cache completion pulse.
- `d_pmem_read`  in  1  D-cache line-read request.
- `d_pmem_write`  in  1  D-cache write-back request.
- `d_pmem_address`  in  ADDR_W  D-cache line address.
- `d_pmem_wdata`  in  LINE_W  D-cache write-back line.
- `d_pmem_rdata`  out  LINE_W  read line to D-cache.
- `d_pmem_resp`  out  1  D-cache completion pulse.
- `pmem_read`  out  1  read request to memory.
- `pmem_write`  out  1  write request to memory.
- `pmem_address`  out  ADDR_W  memory address.
- `pmem_wdata`  out  LINE_W  memory write data.
- `pmem_rdata`  in  LINE_W  memory read data.
- `pmem_resp`  in  1  memory completion, one cycle per transaction.

## Operation

- **States:**
  - `IDLE`: no grant.
  - `GRANT_I`: I-cache transaction active.
  - `GRANT_D`: D-cache transaction active.
  - `TURN`: one-cycle turnaround.
- **Requests:**
  - I request = `i_pmem_read`.
  - D request = `d_pmem_read | d_pmem_write`.
  - If `d_pmem_read` and `d_pmem_write` are both high, the transaction is a write. The read is ignored and re-arbitrated later.
- **IDLE:**
  - Only one requester active: grant it.
  - Both active: grant the requester that was not granted last. The `last_grant` register resets to D, so I-cache wins the first tie.
  - On grant, latch into registers: address, op (read/write), wdata, grant owner. Update `last_grant`.
- **GRANT_x:**
  - `pmem_read`/`pmem_write`, `pmem_address` and `pmem_wdata` are driven from the latched registers, never from live inputs.
  - Hold until `pmem_resp`, then go to `TURN`.
- **TURN:**
  - All pmem requests are low.
  - Next state is `IDLE`.
  - The turnaround lets the served cache drop or re-issue its request before re-arbitration.
- **Responses:**
  - `x_pmem_resp = pmem_resp & (state == GRANT_x)`.
  - The ungranted cache never sees resp.
- **Read data:** `i_pmem_rdata` and `d_pmem_rdata` are both driven by `pmem_rdata` continuously. Data is only meaningful with the corresponding resp.
- **Reset:** `rst` forces `IDLE` and `last_grant = D` from any state. An in-flight memory transaction is abandoned, with no resp forwarded.

## Timing

- **Reset values:**
  - `pmem_read` = 0, `pmem_write` = 0.
  - `pmem_address` = 0, `pmem_wdata` = 0.
  - `i_pmem_resp` = 0, `d_pmem_resp` = 0.
  - Internal state `IDLE`; latched registers 0.
- **Request issue:** a request sampled in `IDLE` at edge N gives `pmem_read`/`pmem_write` high during cycle N+1.
- **Response path:**
  - `pmem_resp` to `x_pmem_resp` is combinational, zero cycles.
  - Arbitration overhead: 1 cycle before and 1 after, via `IDLE` and `TURN`.
- **Back-to-back (same requester):** D-cache write-back followed immediately by its read-allocate:
  - The write-back resp arrives in cycle R.
  - `TURN` occupies R+1.
  - Arbitration happens in `IDLE` at R+2.
  - The read reaches memory at R+3, unless the I-cache wins the round-robin.
- **Input changes mid-transaction:** changes on a granted requester's inputs have no effect until the next grant.
- **Simultaneous `pmem_resp` and `rst`:** reset wins and no resp is forwarded.
- **Protocol errors:** `pmem_resp` outside `GRANT_x` is ignored.
- **Starvation bound:** in round-robin mode, a requester held high is granted within one other transaction.

## Configuration

- **`PMEM_ARB_DPRIO_EN` defined:**
  - Fixed priority: D request beats I request on every tie in `IDLE`.
  - `last_grant` is not used.
  - The I-cache may starve under continuous D traffic.
- **`PMEM_ARB_DPRIO_EN` undefined (default):** round-robin as described in Operation.
- All other behaviour and timing are identical in both modes.

## Test plan

- **Reset:**
  - Stimulus: assert `rst` for 2 cycles with both caches requesting.
  - Required: all outputs 0 during reset; first grant afterwards goes to I (round-robin) or D (`PMEM_ARB_DPRIO_EN`).
- **Single I read:**
  - Stimulus: `i_pmem_read` at address 0x0000_0060; memory responds 3 cycles after `pmem_read` with rdata = 256'hA5…A5.
  - Required: `pmem_read` = 1 and `pmem_address` = 0x60 from the cycle after request; `i_pmem_resp` pulses exactly 1 cycle with `i_pmem_rdata` = A5…; `d_pmem_resp` stays 0.
- **D write-back then read:**
  - Stimulus: `d_pmem_write` at 0x0000_1A0 with wdata = 256'h1234…, then `d_pmem_read` at 0x0000_2A0.
  - Required: `pmem_write` carries the latched data; exactly one `TURN` cycle with pmem idle; then `pmem_read` at 0x2A0.
- **Simultaneous requests, round-robin:**
  - Stimulus: I and D both request continuously for 4 transactions.
  - Required: grants alternate I, D, I, D.
  - With `PMEM_ARB_DPRIO_EN` defined: grants are D, D, D, D.
- **Input perturbation:**
  - Stimulus: while D is granted, I-cache changes `i_pmem_address` and D-cache changes `d_pmem_address`.
  - Required: `pmem_address` holds the latched D address until resp.
- **Mid-transaction reset:**
  - Stimulus: `rst` 2 cycles after grant, with `pmem_resp` pulsed in the same cycle as `rst`.
  - Required: no `x_pmem_resp`; `pmem_read`/`pmem_write` are 0 on the following cycle.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Two-port arbiter serializing I-cache and D-cache line transactions onto one pmem port.
// Round-robin by default; define PMEM_ARB_DPRIO_EN to give the D-cache fixed priority.
module pmem_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StTurn} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                i_req, d_req, pick_d, granted;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_DPRIO_EN
    assign pick_d = d_req;
`else
    logic last_d_q, last_d_d;

    // last_d_q set means the D-cache won the previous arbitration.
    assign pick_d = d_req & (~i_req | ~last_d_q);

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == StIdle && (i_req || d_req)) begin
            last_d_d = pick_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        unique case (state_q)
            StIdle: begin
                if (pick_d) begin
                    state_d = StGrantD;
                    addr_d  = d_pmem_address;
                    wdata_d = d_pmem_wdata;
                    // A simultaneous read is dropped here and re-arbitrated later.
                    write_d = d_pmem_write;
                end else if (i_req) begin
                    state_d = StGrantI;
                    addr_d  = i_pmem_address;
                    wdata_d = '0;
                    write_d = 1'b0;
                end
            end
            StGrantI, StGrantD: begin
                if (pmem_resp) begin
                    state_d = StTurn;
                end
            end
            StTurn:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    assign granted      = (state_q == StGrantI) || (state_q == StGrantD);
    assign pmem_read    = granted & ~write_q;
    assign pmem_write   = granted & write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Reset masks a coincident resp so an abandoned transaction never completes.
    assign i_pmem_resp  = pmem_resp & ~rst & (state_q == StGrantI);
    assign d_pmem_resp  = pmem_resp & ~rst & (state_q == StGrantD);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: per-cycle vector table plus hand-written
// round-robin and input-perturbation sequences.
module tb_pmem_arbiter;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int checks = 0;
    int errors = 0;

    localparam logic [LINE_W-1:0] PatA5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PatW  = {16{16'h1234}};

    pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ir;
        logic [31:0] ia;
        logic        dr, dw;
        logic [31:0] da;
        logic        dwsel, presp, rdsel;
        logic        e_rd, e_wr, e_ir, e_dr;
        logic [31:0] e_addr;
        logic        e_wsel;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic dwsel, input logic presp, input logic rdsel,
                                input logic e_rd, input logic e_wr, input logic e_ir,
                                input logic e_dr, input logic [31:0] e_addr,
                                input logic e_wsel);
        vec_t v;
        v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
        v.dwsel = dwsel; v.presp = presp; v.rdsel = rdsel;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_ir = e_ir; v.e_dr = e_dr;
        v.e_addr = e_addr; v.e_wsel = e_wsel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    vec_t vt[25];

    initial begin
        logic exp_d;
        int   k;

        // rst ir ia    dr dw da     ws pr rs | rd wr ir dr addr   ws
        vt[0]  = mk(1, 1, 32'h40, 1, 0, 32'h80,  0, 0, 0, 0, 0, 0, 0, 32'h0,   0);
        vt[1]  = mk(1, 1, 32'h40, 1, 0, 32'h80,  0, 0, 0, 0, 0, 0, 0, 32'h0,   0);
        vt[2]  = mk(0, 1, 32'h40, 1, 0, 32'h80,  0, 0, 0, 0, 0, 0, 0, 32'h0,   0);
        vt[3]  = mk(0, 1, 32'h40, 1, 0, 32'h80,  0, 1, 1, 1, 0, 1, 0, 32'h40,  0);
        vt[4]  = mk(0, 0, 32'h40, 1, 0, 32'h80,  0, 0, 0, 0, 0, 0, 0, 32'h40,  0);
        vt[5]  = mk(0, 0, 32'h40, 1, 0, 32'h80,  0, 0, 0, 0, 0, 0, 0, 32'h40,  0);
        vt[6]  = mk(0, 0, 32'h40, 1, 0, 32'h80,  0, 1, 1, 1, 0, 0, 1, 32'h80,  0);
        vt[7]  = mk(0, 1, 32'h60, 0, 0, 32'h80,  0, 0, 0, 0, 0, 0, 0, 32'h80,  0);
        vt[8]  = mk(0, 1, 32'h60, 0, 0, 32'h80,  0, 0, 0, 0, 0, 0, 0, 32'h80,  0);
        vt[9]  = mk(0, 1, 32'h60, 0, 0, 32'h80,  0, 0, 0, 1, 0, 0, 0, 32'h60,  0);
        vt[10] = mk(0, 1, 32'h60, 0, 0, 32'h80,  0, 0, 0, 1, 0, 0, 0, 32'h60,  0);
        vt[11] = mk(0, 1, 32'h60, 0, 0, 32'h80,  0, 0, 0, 1, 0, 0, 0, 32'h60,  0);
        vt[12] = mk(0, 1, 32'h60, 0, 0, 32'h80,  0, 1, 1, 1, 0, 1, 0, 32'h60,  0);
        vt[13] = mk(0, 0, 32'h60, 0, 0, 32'h80,  0, 0, 0, 0, 0, 0, 0, 32'h60,  0);
        vt[14] = mk(0, 0, 32'h60, 0, 1, 32'h1A0, 1, 0, 0, 0, 0, 0, 0, 32'h60,  0);
        vt[15] = mk(0, 0, 32'h60, 0, 1, 32'h1A0, 1, 0, 0, 0, 1, 0, 0, 32'h1A0, 1);
        vt[16] = mk(0, 0, 32'h60, 0, 1, 32'h1A0, 1, 1, 0, 0, 1, 0, 1, 32'h1A0, 1);
        vt[17] = mk(0, 0, 32'h60, 1, 0, 32'h2A0, 0, 0, 0, 0, 0, 0, 0, 32'h1A0, 1);
        vt[18] = mk(0, 0, 32'h60, 1, 0, 32'h2A0, 0, 0, 0, 0, 0, 0, 0, 32'h1A0, 1);
        vt[19] = mk(0, 0, 32'h60, 1, 0, 32'h2A0, 0, 1, 1, 1, 0, 0, 1, 32'h2A0, 0);
        vt[20] = mk(0, 0, 32'h60, 0, 0, 32'h2A0, 0, 0, 0, 0, 0, 0, 0, 32'h2A0, 0);
        vt[21] = mk(0, 0, 32'h60, 1, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 32'h2A0, 0);
        vt[22] = mk(0, 0, 32'h60, 1, 0, 32'h300, 0, 0, 0, 1, 0, 0, 0, 32'h300, 0);
        vt[23] = mk(1, 0, 32'h60, 1, 0, 32'h300, 0, 1, 1, 1, 0, 0, 0, 32'h300, 0);
        vt[24] = mk(0, 0, 32'h60, 0, 0, 32'h300, 0, 1, 0, 0, 0, 0, 0, 32'h0,   0);

        rst = 1'b1; i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        @(posedge clk);

        for (int s = 0; s < 25; s++) begin
            #1;
            rst            = vt[s].rst;
            i_pmem_read    = vt[s].ir;
            i_pmem_address = vt[s].ia;
            d_pmem_read    = vt[s].dr;
            d_pmem_write   = vt[s].dw;
            d_pmem_address = vt[s].da;
            d_pmem_wdata   = vt[s].dwsel ? PatW : '0;
            pmem_resp      = vt[s].presp;
            pmem_rdata     = vt[s].rdsel ? PatA5 : '0;
            @(negedge clk);
            chk($sformatf("step%0d ctl", s),
                LINE_W'({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address}),
                LINE_W'({vt[s].e_rd, vt[s].e_wr, vt[s].e_ir, vt[s].e_dr, vt[s].e_addr}));
            chk($sformatf("step%0d wdata", s), pmem_wdata, vt[s].e_wsel ? PatW : '0);
            if (vt[s].presp) begin
                chk($sformatf("step%0d rdata", s),
                    LINE_W'({i_pmem_rdata == PatA5, d_pmem_rdata == PatA5}),
                    LINE_W'({vt[s].rdsel, vt[s].rdsel}));
            end
            @(posedge clk);
        end

        // Continuous tie: grants alternate starting with I after reset.
        #1;
        pmem_resp = 1'b0; pmem_rdata = '0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h100;
        d_pmem_read = 1'b1; d_pmem_address = 32'h200;
        for (int n = 0; n < 4; n++) begin
`ifdef PMEM_ARB_DPRIO_EN
            exp_d = 1'b1;
`else
            exp_d = (n % 2) == 1;
`endif
            k = 0;
            @(negedge clk);
            while (!(pmem_read || pmem_write) && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("rr%0d grant timeout", n), LINE_W'(k < 10), LINE_W'(1));
            chk($sformatf("rr%0d owner", n), LINE_W'(pmem_address),
                LINE_W'(exp_d ? 32'h200 : 32'h100));
            pmem_resp = 1'b1;
            #1;
            chk($sformatf("rr%0d resp", n), LINE_W'({i_pmem_resp, d_pmem_resp}),
                LINE_W'({~exp_d, exp_d}));
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
        end

        // Read+write together is a write; later input changes must not leak through.
        i_pmem_read = 1'b0; d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        d_pmem_address = 32'h400; d_pmem_wdata = PatW;
        k = 0;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("dual op", LINE_W'({pmem_read, pmem_write}), LINE_W'(2'b01));
        @(posedge clk);
        #1;
        d_pmem_address = 32'h500; d_pmem_wdata = '0; d_pmem_write = 1'b0;
        i_pmem_address = 32'h600; i_pmem_read = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("perturb%0d addr", c), LINE_W'(pmem_address), LINE_W'(32'h400));
            chk($sformatf("perturb%0d wdata", c), pmem_wdata, PatW);
        end
        pmem_resp = 1'b1;
        #1;
        chk("perturb resp", LINE_W'({i_pmem_resp, d_pmem_resp}), LINE_W'(2'b01));
        @(posedge clk);
        #1;
        pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
        @(negedge clk);
        chk("turn idle", LINE_W'({pmem_read, pmem_write}), LINE_W'(2'b00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
